// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the configuration-column frame registers: row address helpers,
// parity helper and the per-row FSM encoding.
package frame_cfg_pkg;

    localparam int ROW_IDLE = 0;

    // Widest frame word the parity helper covers; callers zero-extend into it.
    localparam int FRAME_MAX_BITS = 64;

    typedef enum logic {
        FDR_EMPTY   = 1'b0,
        FDR_PENDING = 1'b1
    } fdr_state_t;

    // All-ones row address of the given width; used as the broadcast select.
    function automatic logic [31:0] row_broadcast(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Even-parity bit: makes the total count of ones (data + bit) even.
    function automatic logic even_parity(input logic [FRAME_MAX_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/frame_pipe_stage.sv
// One retiming register on the column forward path, cleared by the asynchronous reset.
module frame_pipe_stage #(
    parameter int Width = 1
) (
    input  logic             CLK,
    input  logic             resetn,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_q;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/frame_data_reg_buffered.sv
// Per-row frame-data register: shadow capture on address match, commit to the tile on Commit_I,
// sticky error flags, saturating capture count and a retimed forward path down the column.
module frame_data_reg_buffered
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int RowSelectWidth  = 5,
    parameter int Row             = 1,
    parameter int PipeStages      = 1,
    parameter int BroadcastEnable = 1,
    parameter int ParityEnable    = 1,
    parameter int CountWidth      = 8
) (
    input  logic                       CLK,
    input  logic                       resetn,
    input  logic [FrameBitsPerRow-1:0] FrameData_I,
    input  logic [RowSelectWidth-1:0]  RowSelect_I,
    input  logic                       FrameValid_I,
    input  logic                       FrameParity_I,
    input  logic                       Commit_I,
    input  logic                       ClearErr_I,
    output logic [FrameBitsPerRow-1:0] FrameData_O,
    output logic                       Pending_O,
    output logic                       ParityErr_O,
    output logic                       Overrun_O,
    output logic [CountWidth-1:0]      CaptureCount_O,
    output logic [FrameBitsPerRow-1:0] FrameData_Fwd_O,
    output logic [RowSelectWidth-1:0]  RowSelect_Fwd_O,
    output logic                       FrameValid_Fwd_O,
    output logic                       FrameParity_Fwd_O
);

    localparam logic [RowSelectWidth-1:0] SEL_IDLE  = RowSelectWidth'(ROW_IDLE);
    localparam logic [RowSelectWidth-1:0] SEL_ROW   = RowSelectWidth'(Row);
    localparam logic [RowSelectWidth-1:0] SEL_BCAST = RowSelectWidth'(row_broadcast(RowSelectWidth));
    localparam int                        PW        = FrameBitsPerRow + RowSelectWidth + 2;

    fdr_state_t                 r_state, w_state_next;
    logic [FrameBitsPerRow-1:0] r_shadow;
    logic [FrameBitsPerRow-1:0] r_frame_data;
    logic [CountWidth-1:0]      r_count;
    logic                       r_parity_err;
    logic                       r_overrun;

    logic [FRAME_MAX_BITS-1:0]  w_data_ext;
    logic                       w_match;
    logic                       w_par_ok;
    logic                       w_accept;
    logic                       w_par_fail;
    logic                       w_commit;
    logic                       w_overrun_set;

    assign w_data_ext = FRAME_MAX_BITS'(FrameData_I);
    assign w_match    = FrameValid_I && (RowSelect_I != SEL_IDLE) &&
                        ((RowSelect_I == SEL_ROW) ||
                         ((BroadcastEnable != 0) && (RowSelect_I == SEL_BCAST)));
    assign w_par_ok   = (ParityEnable == 0) || (even_parity(w_data_ext) == FrameParity_I);
    assign w_accept   = w_match && w_par_ok;
    assign w_par_fail = w_match && !w_par_ok;

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state <= FDR_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A commit always drains the old shadow, even when a new frame lands in the same cycle.
    always_comb begin
        w_state_next  = r_state;
        w_commit      = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            FDR_EMPTY: begin
                if (w_accept) w_state_next = FDR_PENDING;
            end
            FDR_PENDING: begin
                if (Commit_I) begin
                    w_commit = 1'b1;
                    if (!w_accept) w_state_next = FDR_EMPTY;
                end else if (w_accept) begin
                    w_overrun_set = 1'b1;
                end
            end
            default: w_state_next = FDR_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_shadow     <= '0;
            r_frame_data <= '0;
            r_count      <= '0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_accept) r_shadow <= FrameData_I;
            if (w_commit) r_frame_data <= r_shadow;
            if (w_accept && (r_count != '1)) r_count <= r_count + CountWidth'(1);
            // Setting has priority over a same-cycle clear so no error is lost.
            if (w_par_fail)      r_parity_err <= 1'b1;
            else if (ClearErr_I) r_parity_err <= 1'b0;
            if (w_overrun_set)   r_overrun <= 1'b1;
            else if (ClearErr_I) r_overrun <= 1'b0;
        end
    end

    assign FrameData_O    = r_frame_data;
    assign Pending_O      = (r_state == FDR_PENDING);
    assign ParityErr_O    = r_parity_err;
    assign Overrun_O      = r_overrun;
    assign CaptureCount_O = r_count;

    // Entry 0 is the raw input, so PipeStages=0 degenerates to a plain wire.
    logic [PW-1:0] w_pipe [0:PipeStages];

    assign w_pipe[0] = {FrameData_I, RowSelect_I, FrameValid_I, FrameParity_I};

    for (genvar g = 0; g < PipeStages; g++) begin : g_pipe
        frame_pipe_stage #(.Width(PW)) u_stage (
            .CLK    (CLK),
            .resetn (resetn),
            .i_d    (w_pipe[g]),
            .o_q    (w_pipe[g+1])
        );
    end

    assign {FrameData_Fwd_O, RowSelect_Fwd_O, FrameValid_Fwd_O, FrameParity_Fwd_O} = w_pipe[PipeStages];

endmodule
